fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO with occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a selectable read mode (registered read or first-word-fall-through).
Successor to the team's basic synchronous FIFO.
Used as the standard elastic buffer between streaming blocks, such as UART/SPI byte paths and DMA staging.

Parameters:
DATA_WIDTH, 8, bits per entry (>=1)
DEPTH, 16, number of entries; power of two, >=2; elaboration error otherwise
FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read request (FWFT: pop/acknowledge the head)
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  mode 0: rd_data valid this cycle; mode 1: equals !empty
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while blocked
underflow  out  1  sticky: read attempted while empty
clear_err  in  1  clears overflow/underflow

Behaviour:
- Reset (synchronous): both pointers, count, rd_data, rd_valid, overflow and underflow go to 0.
  - Resulting flags: empty=1, full=0, almost_full=0, almost_empty=1.
  - Memory contents are not reset.
  - Reset mid-operation discards all entries; the cycle after reset is identical to power-up.
- Pointers are clog2(DEPTH)+1 bits. The MSB is a wrap bit, and the low bits index memory. They wrap naturally at 2*DEPTH.
- Read accept: rd_acc = rd_en && !empty.
- Write accept: wr_acc = wr_en && (!full || rd_acc). A write is allowed on full when a read is accepted in the same cycle.
- count next = count + wr_acc - rd_acc. It never exceeds DEPTH and never underflows. All status flags are derived combinationally from the registered count.
- Simultaneous read and write:
  - Non-empty, non-full: both accepted, count unchanged.
  - Empty: write accepted, read rejected (underflow set), count becomes 1.
  - Full: both accepted, count stays DEPTH.
- Mode FWFT=0:
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 on the next edge. Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Latency: data appears 1 cycle after the accepted read.
- Mode FWFT=1:
  - rd_data = mem[rd_ptr] combinationally and rd_valid = !empty.
  - A word written at edge N is visible on rd_data after edge N; rd_en at that point pops it at edge N+1.
  - When empty, rd_data is don't-care.
- Error flags:
  - overflow <= 1 when wr_en && !wr_acc.
  - underflow <= 1 when rd_en && !rd_acc.
  - A set condition in the same cycle as clear_err wins.
  - Flags are only cleared by clear_err or reset.
- Rejected writes drop data; memory and pointers are unchanged.
- All outputs are glitch-free relative to clk. No combinational path from wr_en or rd_en to any status flag.

Decomposition:
- Shared package / include (fifo_defs): helper clog2-based width constants and threshold-check macros, reused by future async FIFO work.
- One sub-module, fifo_ram: DATA_WIDTH x DEPTH register array with one synchronous write port and one asynchronous read port.
  - Instantiated once.
  - Keeps storage swappable for a BRAM wrapper later.
- Pointer, count, flag and read-mode logic stays in fifo_sync_flags.

Test Plan:
- Fill/drain, DATA_WIDTH=8, DEPTH=16, FWFT=0:
  - Stimulus: write 0x00..0x0F, then 17 reads.
  - Fill response: full after the 16th write; count=16; almost_full from count=14.
  - Drain response: rd_data 0x00..0x0F, each 1 cycle after rd_en, with rd_valid pulses; 17th read sets underflow; empty=1; almost_empty at count<=2.
- Overflow on full:
  - Stimulus: 17th write 0xAA with no read.
  - Response: overflow=1, count stays 16, a subsequent drain never returns 0xAA. clear_err returns overflow to 0.
- Full + simultaneous read/write:
  - Stimulus: at count=16, wr_en=1 (0x55) and rd_en=1.
  - Response: no overflow, count=16, 0x55 is read last after draining.
- Empty + simultaneous read/write:
  - Stimulus: at count=0, wr 0x33 with rd_en=1.
  - Response: underflow=1, count=1, next read returns 0x33.
- FWFT=1:
  - Stimulus: write 0x12 at edge N, then rd_en.
  - Response: rd_data=0x12 and rd_valid=1 after edge N with no read; rd_en pops it; empty=1 afterwards.
- Reset mid-stream:
  - Stimulus: at count=7 with overflow set, assert reset for 1 cycle.
  - Response: count=0, empty=1, overflow=0, rd_valid=0. A new write then read returns the new data, not stale entries.

Source files
------------

// File: rtl/fifo_defs.sv
// ---------------------------------------------------------------------------
// fifo_defs
// Shared helpers for the FIFO family (this synchronous FIFO now, the async
// FIFO later). Provides pointer/count width derivation, the power-of-two
// depth check and the threshold-range checks used at elaboration time.
// No ports: package only.
// ---------------------------------------------------------------------------
package fifo_defs;

    // Pointers carry one extra wrap bit above the memory index so that
    // full and empty are distinguishable when the low bits are equal.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit af_thresh_ok(input int thresh, input int depth);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

    function automatic bit ae_thresh_ok(input int thresh, input int depth);
        return (thresh >= 0) && (thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// DATA_WIDTH x DEPTH register array with one synchronous write port and one
// asynchronous read port. Kept as its own module so the storage can later be
// swapped for a BRAM wrapper without touching the FIFO control logic.
// Contents are deliberately not reset.
//
// Ports:
//   clk      in   clock, write on rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   write data
//   rd_addr  in   read index
//   rd_data  out  mem[rd_addr], combinational
// ---------------------------------------------------------------------------
module fifo_ram
    import fifo_defs::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_flags.sv
// ---------------------------------------------------------------------------
// fifo_sync_flags
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds, sticky overflow / underflow flags and a choice of
// registered read (FWFT=0, one cycle latency) or first-word-fall-through
// (FWFT=1). All status flags decode the registered count only, so there is
// no combinational path from wr_en / rd_en to any flag.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-high
//   wr_en         in   write request
//   wr_data       in   write data
//   rd_en         in   read request (FWFT: pop the head)
//   rd_data       out  read data
//   rd_valid      out  FWFT=0: rd_data valid this cycle; FWFT=1: !empty
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_THRESH
//   almost_empty  out  count <= AE_THRESH
//   count         out  occupancy 0..DEPTH
//   overflow      out  sticky: write attempted while blocked
//   underflow     out  sticky: read attempted while empty
//   clear_err     in   clears overflow / underflow
// ---------------------------------------------------------------------------
module fifo_sync_flags
    import fifo_defs::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [ptr_width(DEPTH)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clear_err
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = addr_width(DEPTH);

    localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_CNT    = PW'(AE_THRESH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_sync_flags: DEPTH must be a power of two >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("fifo_sync_flags: DATA_WIDTH must be >= 1");
    end
    if (!af_thresh_ok(AF_THRESH, DEPTH)) begin : g_bad_af
        $error("fifo_sync_flags: AF_THRESH must be in 1..DEPTH");
    end
    if (!ae_thresh_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
        $error("fifo_sync_flags: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A write on full is still taken when a read frees a slot in the same
    // cycle; the read itself is only ever blocked by empty.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_rd_data)
    );

    // Pointers wrap naturally at 2*DEPTH; count tracks the net of accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: a new error in the same cycle as clear_err wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

    if (FWFT == 0) begin : g_reg_read
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        // Registered read: rd_data holds its last value between reads.
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (rd_acc) begin
                rd_data_q  <= ram_rd_data;
                rd_valid_q <= 1'b1;
            end else begin
                rd_valid_q <= 1'b0;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft
        // Head of queue is always presented; rd_en acknowledges it.
        assign rd_data  = ram_rd_data;
        assign rd_valid = !empty;
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_flags
// Directed bench for fifo_sync_flags. Reads on the registered-read instance
// push their expected data into a queue; an independent monitor pops and
// compares whenever rd_valid is seen. A second FWFT instance covers the
// fall-through path.
// ---------------------------------------------------------------------------
module tb_fifo_sync_flags;

    logic       clk;
    logic       reset;

    // Registered-read instance
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       clear_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    // FWFT instance
    logic       f_wr_en;
    logic [7:0] f_wr_data;
    logic       f_rd_en;
    logic       f_clear_err;
    logic [7:0] f_rd_data;
    logic       f_rd_valid;
    logic       f_full;
    logic       f_empty;
    logic       f_almost_full;
    logic       f_almost_empty;
    logic [4:0] f_count;
    logic       f_overflow;
    logic       f_underflow;

    int vectors;
    int miscompares;
    logic [7:0] exp_q[$];

    fifo_sync_flags #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .FWFT       (0),
        .AF_THRESH  (14),
        .AE_THRESH  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clear_err    (clear_err)
    );

    fifo_sync_flags #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .FWFT       (1),
        .AF_THRESH  (14),
        .AE_THRESH  (2)
    ) dut_fwft (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (f_wr_en),
        .wr_data      (f_wr_data),
        .rd_en        (f_rd_en),
        .rd_data      (f_rd_data),
        .rd_valid     (f_rd_valid),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_almost_full),
        .almost_empty (f_almost_empty),
        .count        (f_count),
        .overflow     (f_overflow),
        .underflow    (f_underflow),
        .clear_err    (f_clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle on the registered-read instance. A read the bench knows will
    // be accepted pushes its expected data before the edge.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r,
                                 input logic clr, input logic push, input logic [7:0] exp_d);
        wr_en     = w;
        wr_data   = d;
        rd_en     = r;
        clear_err = clr;
        if (push) exp_q.push_back(exp_d);
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic applyFwft(input logic w, input logic [7:0] d, input logic r);
        f_wr_en   = w;
        f_wr_data = d;
        f_rd_en   = r;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0;
        f_rd_en = 1'b0;
    endtask

    // Scoreboard monitor: every rd_valid pulse must match the next expectation.
    always @(posedge clk) begin
        #1;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL rd_valid_unexpected: got data %0h expected no read at %0t",
                         rd_data, $time);
            end else begin
                checkOutput("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr_en = 0; wr_data = 0; rd_en = 0; clear_err = 0;
        f_wr_en = 0; f_wr_data = 0; f_rd_en = 0; f_clear_err = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        checkOutput("rst_count", {27'd0, count}, 32'd0);
        checkOutput("rst_empty", {31'd0, empty}, 32'd1);
        checkOutput("rst_full", {31'd0, full}, 32'd0);
        checkOutput("rst_af", {31'd0, almost_full}, 32'd0);
        checkOutput("rst_ae", {31'd0, almost_empty}, 32'd1);
        checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("rst_unf", {31'd0, underflow}, 32'd0);
        checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);

        // FWFT: word written at an edge is visible right after it
        applyFwft(1'b1, 8'h12, 1'b0);
        checkOutput("fwft_data", {24'd0, f_rd_data}, 32'h12);
        checkOutput("fwft_valid", {31'd0, f_rd_valid}, 32'd1);
        checkOutput("fwft_count", {27'd0, f_count}, 32'd1);
        applyFwft(1'b1, 8'h34, 1'b1);
        checkOutput("fwft_head2", {24'd0, f_rd_data}, 32'h34);
        applyFwft(1'b0, 8'h00, 1'b1);
        checkOutput("fwft_empty", {31'd0, f_empty}, 32'd1);
        checkOutput("fwft_valid_off", {31'd0, f_rd_valid}, 32'd0);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 8'h00);
            checkOutput("fill_count", {27'd0, count}, 32'(i + 1));
            checkOutput("fill_af", {31'd0, almost_full}, {31'd0, (i + 1) >= 14});
            checkOutput("fill_ae", {31'd0, almost_empty}, {31'd0, (i + 1) <= 2});
            checkOutput("fill_full", {31'd0, full}, {31'd0, (i + 1) == 16});
        end

        // Overflow on full: 0xAA dropped
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
        checkOutput("ovf_count", {27'd0, count}, 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("ovf_clear", {31'd0, overflow}, 32'd0);

        // Full + simultaneous read/write: both accepted
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("full_rw_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("full_rw_count", {27'd0, count}, 32'd16);

        // Drain: 0x01..0x0F then 0x55
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, (i == 16) ? 8'h55 : 8'(i));
            checkOutput("drain_count", {27'd0, count}, 32'(16 - i));
            checkOutput("drain_ae", {31'd0, almost_empty}, {31'd0, (16 - i) <= 2});
        end
        checkOutput("drain_empty", {31'd0, empty}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("unf_set", {31'd0, underflow}, 32'd1);
        checkOutput("unf_no_valid", {31'd0, rd_valid}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("unf_clear", {31'd0, underflow}, 32'd0);

        // Empty + simultaneous read/write: write only
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("empty_rw_unf", {31'd0, underflow}, 32'd1);
        checkOutput("empty_rw_count", {27'd0, count}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33);
        checkOutput("empty_rw_drain", {27'd0, count}, 32'd0);
        checkOutput("clear_unf", {31'd0, underflow}, 32'd0);

        // Reset mid-stream with count=7 and overflow set
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, 8'h00);
        end
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC0 + 8'(i));
        end
        checkOutput("pre_rst_count", {27'd0, count}, 32'd7);
        checkOutput("pre_rst_ovf", {31'd0, overflow}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("mid_rst_count", {27'd0, count}, 32'd0);
        checkOutput("mid_rst_empty", {31'd0, empty}, 32'd1);
        checkOutput("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("post_rst_empty", {31'd0, empty}, 32'd1);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
